alu_multibyte_sequencer: RTL and testbench
==========================================

Name: alu_multibyte_sequencer

Overview:
- Sequences the 8-bit ALU to execute one multi-byte (NBYTES×8-bit) operation, one byte per cycle, chaining carry/shift bits through SC_IN/SC_OUT.
- Sits between the control unit (request/response handshakes) and the combinational 8-bit ALU, whose operand, opcode and carry-in ports it drives.
- Assembles the wide result, final carry and whole-word zero flag.

Parameters:
- NBYTES, 2, number of bytes per operand. Legal range is ≥1. Word width W = 8*NBYTES.

Ports:
- CLK  input  1  clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- REQ_VALID  input  1  request present
- REQ_READY  output  1  sequencer can accept a request
- REQ_OP  input  3  0=ADD 1=SUB 2=AND 3=XOR 4=SHL 5=SHR; 6,7 are invalid
- REQ_A  input  W  operand A
- REQ_B  input  W  operand B; ignored for SHL and SHR
- REQ_CIN  input  1  carry-in for ADD, shift-in for SHL/SHR
- ALU_A  output  8  ALU INPUT_A byte
- ALU_B  output  8  ALU INPUT_B byte
- ALU_OP  output  3  ALU opcode: kADD=0 kLSH=1 kRSH=2 kXOR=3 kAND=4
- ALU_SC_IN  output  1  ALU shift/carry in
- ALU_RESULT  input  8  ALU OUTPUT
- ALU_SC_OUT  input  1  ALU shift/carry out
- RSP_VALID  output  1  result available
- RSP_READY  input  1  consumer accepts result
- RSP_RESULT  output  W  assembled result
- RSP_COUT  output  1  final carry/shift-out
- RSP_ZERO  output  1  RSP_RESULT == 0

Behaviour:
- Reset values: state IDLE, REQ_READY=1, RSP_VALID=0, RSP_RESULT=0, RSP_COUT=0, RSP_ZERO=0, ALU_A/ALU_B/ALU_OP/ALU_SC_IN=0.
- Reset is asynchronous. Asserting it mid-operation aborts the operation with no response and returns all outputs to reset values.
- State IDLE:
  - REQ_READY=1.
  - On REQ_VALID&&REQ_READY at an edge: latch op, A, B and CIN; clear byte index and result; go to RUN.
- State RUN:
  - REQ_READY=0.
  - Each cycle, present byte i of the latched operands to the ALU.
  - Each edge, capture ALU_RESULT into byte i of the result and ALU_SC_OUT into the carry register.
  - After NBYTES cycles, go to DONE.
- State DONE:
  - RSP_VALID=1; RSP_RESULT, RSP_COUT and RSP_ZERO are held stable.
  - On RSP_READY, go to IDLE, with RSP_VALID=0 next cycle.
  - A new request is accepted only in IDLE, never in the same cycle as the response.
- Latency: request accepted at edge k → RSP_VALID=1 from cycle k+NBYTES+1. Throughput is one operation per NBYTES+2 cycles with RSP_READY held high.
- Byte order: LSB first for ADD, SUB, AND, XOR and SHL; MSB first for SHR.
- Byte-0 carry-in: REQ_CIN for ADD, SHL and SHR; 1 for SUB; 0 for AND and XOR. Later bytes use the carry register, i.e. the previous ALU_SC_OUT.
- Per-op ALU drive:
  - ADD: ALU_OP=kADD, B=B byte.
  - SUB: ALU_OP=kADD, B=~B byte. The ALU's native subtract does not produce a carry, so it is not used. RSP_COUT=1 means no borrow.
  - AND: ALU_OP=kAND. RSP_COUT=0.
  - XOR: ALU_OP=kXOR. RSP_COUT=0.
  - SHL: ALU_OP=kLSH, B=0. ALU contract: OUT={A[6:0],SC_IN}, SC_OUT=A[7].
  - SHR: ALU_OP=kRSH, B=0. ALU contract: OUT={SC_IN,A[7:1]}, SC_OUT=A[0].
- Invalid op (6,7): accepted with normal latency. ALU outputs are driven 0 during RUN. Response is RESULT=0, COUT=0, ZERO=1.
- RSP_ZERO is computed from the fully assembled RSP_RESULT, not from per-byte ALU flags.
- Outside RUN, all ALU_* outputs are 0.
- REQ_* inputs are not sampled outside the accept edge. Changing them during RUN has no effect.

Test Plan:
- ADD 0x00FF+0x0001, CIN=0, RSP_READY=1 → RESULT=0x0100, COUT=0, ZERO=0. Accept at edge k; RSP_VALID first high at cycle k+3 (NBYTES=2). ALU_SC_IN=1 in the second RUN cycle.
- SUB 0x1000−0x0001 → 0x0FFF, COUT=1. SUB 0x0000−0x0001 → 0xFFFF, COUT=0. Check ALU_B=0xFE then 0xFF and ALU_SC_IN=1 in the first RUN cycle.
- SHL 0x8001, CIN=1 → 0x0003, COUT=1. SHR 0x0101, CIN=0 → 0x0080, COUT=1; check ALU_A=0x01 (MSB byte) in the first RUN cycle.
- AND 0xF0F0&0x0F0F → 0x0000, ZERO=1, COUT=0. XOR 0xAAAA^0xFFFF → 0x5555, ZERO=0. Invalid op 7 → 0x0000, ZERO=1, same latency.
- Backpressure: hold RSP_READY=0 for 3 cycles in DONE. RSP_VALID and RESULT stay stable and REQ_READY=0 throughout; a pending REQ_VALID is accepted only on the first IDLE cycle after the handshake.
- Assert RESET during the second RUN cycle → all outputs at reset values immediately; after release no RSP_VALID appears and REQ_READY=1. A fresh ADD then completes correctly.

Source files
------------

// File: rtl/alu_multibyte_sequencer.sv
//==============================================================================
// Module   : alu_multibyte_sequencer
// Brief    : Runs one NBYTES-wide operation through an 8-bit ALU, one byte per
//            cycle, chaining carry/shift bits and assembling the wide result.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_multibyte_sequencer #(
    parameter int NBYTES = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic [2:0]          REQ_OP,
    input  logic [8*NBYTES-1:0] REQ_A,
    input  logic [8*NBYTES-1:0] REQ_B,
    input  logic                REQ_CIN,
    output logic [7:0]          ALU_A,
    output logic [7:0]          ALU_B,
    output logic [2:0]          ALU_OP,
    output logic                ALU_SC_IN,
    input  logic [7:0]          ALU_RESULT,
    input  logic                ALU_SC_OUT,
    output logic                RSP_VALID,
    input  logic                RSP_READY,
    output logic [8*NBYTES-1:0] RSP_RESULT,
    output logic                RSP_COUT,
    output logic                RSP_ZERO
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NBYTES - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [2:0] c_op_add = 3'd0;
    localparam logic [2:0] c_op_sub = 3'd1;
    localparam logic [2:0] c_op_and = 3'd2;
    localparam logic [2:0] c_op_xor = 3'd3;
    localparam logic [2:0] c_op_shl = 3'd4;
    localparam logic [2:0] c_op_shr = 3'd5;

    localparam logic [2:0] c_alu_add = 3'd0;
    localparam logic [2:0] c_alu_lsh = 3'd1;
    localparam logic [2:0] c_alu_rsh = 3'd2;
    localparam logic [2:0] c_alu_xor = 3'd3;
    localparam logic [2:0] c_alu_and = 3'd4;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [2:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_result;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;

    logic [IDXW-1:0] w_pos;
    logic [7:0]      w_a_byte;
    logic [7:0]      w_b_byte;
    logic [7:0]      w_byte_res;
    logic            w_valid_op;
    logic            w_has_cout;
    logic            w_cin0;
    logic            w_last;

    // SHR walks the word MSB first so the shift-in bit enters at the top.
    assign w_pos      = (r_op == c_op_shr) ? (c_last_idx - r_idx) : r_idx;
    assign w_a_byte   = 8'(r_a >> {w_pos, 3'b000});
    assign w_b_byte   = 8'(r_b >> {w_pos, 3'b000});
    assign w_valid_op = (r_op < 3'd6);
    assign w_byte_res = w_valid_op ? ALU_RESULT : 8'h00;
    assign w_last     = (r_idx == c_last_idx);
    assign w_has_cout = (r_op == c_op_add) || (r_op == c_op_sub) ||
                        (r_op == c_op_shl) || (r_op == c_op_shr);

    always_comb begin
        case (REQ_OP)
            c_op_add, c_op_shl, c_op_shr: w_cin0 = REQ_CIN;
            c_op_sub:                     w_cin0 = 1'b1;
            default:                      w_cin0 = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (REQ_VALID) w_next_state = c_run;
            c_run:   if (w_last)    w_next_state = c_done;
            c_done:  if (RSP_READY) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // Operand latch, byte index, carry chain and result assembly.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_op     <= 3'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (REQ_VALID) begin
                        r_op     <= REQ_OP;
                        r_a      <= REQ_A;
                        r_b      <= REQ_B;
                        r_carry  <= w_cin0;
                        r_idx    <= '0;
                        r_result <= '0;
                    end
                end
                c_run: begin
                    r_result <= (r_result & ~(W'(8'hFF) << {w_pos, 3'b000})) |
                                (W'(w_byte_res) << {w_pos, 3'b000});
                    r_carry  <= w_valid_op ? ALU_SC_OUT : 1'b0;
                    r_idx    <= r_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        REQ_READY  = (r_state == c_idle);
        RSP_VALID  = (r_state == c_done);
        RSP_RESULT = r_result;
        RSP_COUT   = w_has_cout & r_carry;
        RSP_ZERO   = (r_state == c_done) && (r_result == '0);
        ALU_A      = 8'h00;
        ALU_B      = 8'h00;
        ALU_OP     = 3'd0;
        ALU_SC_IN  = 1'b0;
        if ((r_state == c_run) && w_valid_op) begin
            ALU_A     = w_a_byte;
            ALU_SC_IN = r_carry;
            case (r_op)
                c_op_add: begin ALU_OP = c_alu_add; ALU_B = w_b_byte;  end
                // Subtract as A + ~B + 1 so the ALU's carry-out is the no-borrow flag.
                c_op_sub: begin ALU_OP = c_alu_add; ALU_B = ~w_b_byte; end
                c_op_and: begin ALU_OP = c_alu_and; ALU_B = w_b_byte;  end
                c_op_xor: begin ALU_OP = c_alu_xor; ALU_B = w_b_byte;  end
                c_op_shl: ALU_OP = c_alu_lsh;
                c_op_shr: ALU_OP = c_alu_rsh;
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_multibyte_sequencer.sv
//==============================================================================
// Module   : tb_alu_multibyte_sequencer
// Brief    : Bench for alu_multibyte_sequencer with a behavioural 8-bit ALU and
//            a word-level reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_multibyte_sequencer;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic [2:0]    REQ_OP = 3'd0;
    logic [W-1:0]  REQ_A = '0;
    logic [W-1:0]  REQ_B = '0;
    logic          REQ_CIN = 1'b0;
    logic [7:0]    ALU_A;
    logic [7:0]    ALU_B;
    logic [2:0]    ALU_OP;
    logic          ALU_SC_IN;
    logic [7:0]    ALU_RESULT;
    logic          ALU_SC_OUT;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b1;
    logic [W-1:0]  RSP_RESULT;
    logic          RSP_COUT;
    logic          RSP_ZERO;

    always #5 CLK = ~CLK;

    alu_multibyte_sequencer #(.NBYTES(NB)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_OP     (REQ_OP),
        .REQ_A      (REQ_A),
        .REQ_B      (REQ_B),
        .REQ_CIN    (REQ_CIN),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_OP     (ALU_OP),
        .ALU_SC_IN  (ALU_SC_IN),
        .ALU_RESULT (ALU_RESULT),
        .ALU_SC_OUT (ALU_SC_OUT),
        .RSP_VALID  (RSP_VALID),
        .RSP_READY  (RSP_READY),
        .RSP_RESULT (RSP_RESULT),
        .RSP_COUT   (RSP_COUT),
        .RSP_ZERO   (RSP_ZERO)
    );

    // Combinational 8-bit ALU: kADD=0 kLSH=1 kRSH=2 kXOR=3 kAND=4.
    always_comb begin
        ALU_RESULT = 8'h00;
        ALU_SC_OUT = 1'b0;
        case (ALU_OP)
            3'd0: {ALU_SC_OUT, ALU_RESULT} = 9'(ALU_A) + 9'(ALU_B) + 9'(ALU_SC_IN);
            3'd1: begin ALU_RESULT = {ALU_A[6:0], ALU_SC_IN}; ALU_SC_OUT = ALU_A[7]; end
            3'd2: begin ALU_RESULT = {ALU_SC_IN, ALU_A[7:1]}; ALU_SC_OUT = ALU_A[0]; end
            3'd3: ALU_RESULT = ALU_A ^ ALU_B;
            3'd4: ALU_RESULT = ALU_A & ALU_B;
            default: begin
            end
        endcase
    end

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  cap_a  [8];
    logic [7:0]  cap_b  [8];
    logic        cap_sc [8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Whole-word model of each operation.
    function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic cin,
                                      output logic [W-1:0] res, output logic cout);
        logic [W:0] s;
        res  = '0;
        cout = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b} + (W+1)'(cin); res = s[W-1:0]; cout = s[W]; end
            3'd1: begin res = a - b; cout = (a >= b); end
            3'd2: res = a & b;
            3'd3: res = a ^ b;
            3'd4: begin res = {a[W-2:0], cin}; cout = a[W-1]; end
            3'd5: begin res = {cin, a[W-1:1]}; cout = a[0]; end
            default: begin
            end
        endcase
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the first RUN cycle.
    task automatic start_req(input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic cin);
        REQ_VALID = 1'b1;
        REQ_OP    = op;
        REQ_A     = a;
        REQ_B     = b;
        REQ_CIN   = cin;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        REQ_OP    = 3'($urandom);
        REQ_A     = W'($urandom);
        REQ_B     = W'($urandom);
        REQ_CIN   = 1'($urandom);
    endtask

    task automatic collect(output int n);
        n = 0;
        while (RSP_VALID !== 1'b1 && n < 20) begin
            if (n < 8) begin
                cap_a[n]  = ALU_A;
                cap_b[n]  = ALU_B;
                cap_sc[n] = ALU_SC_IN;
            end
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin, input logic [W-1:0] er,
                           input logic ec, input logic ez);
        int n;
        RSP_READY = 1'b1;
        start_req(op, a, b, cin);
        collect(n);
        check({tag, "_latency"}, n, NB);
        check({tag, "_result"}, RSP_RESULT, er);
        check({tag, "_cout"}, RSP_COUT, ec);
        check({tag, "_zero"}, RSP_ZERO, ez);
        @(negedge CLK);
    endtask

    vec_t vecs[9];

    initial begin
        int n;
        logic [W-1:0] er;
        logic ec;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;
        logic rc;

        vecs[0] = '{3'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[2] = '{3'd1, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b1, 1'b0};
        vecs[3] = '{3'd4, 16'h8001, 16'h1234, 1'b1, 16'h0003, 1'b1, 1'b0};
        vecs[4] = '{3'd5, 16'h0101, 16'hFFFF, 1'b0, 16'h0080, 1'b1, 1'b0};
        vecs[5] = '{3'd2, 16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{3'd3, 16'hAAAA, 16'hFFFF, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[7] = '{3'd7, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[8] = '{3'd0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};

        #1;
        check("reset_outputs",
              {REQ_READY, RSP_VALID, RSP_RESULT, RSP_COUT, RSP_ZERO, ALU_A, ALU_B, ALU_OP, ALU_SC_IN},
              {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0});
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].res, vecs[i].cout, vecs[i].zero);
            if (i == 0) check("add_sc_in_byte1", cap_sc[1], 1'b1);
            if (i == 1) begin
                check("sub_alu_b_byte0", cap_b[0], 8'hFE);
                check("sub_alu_b_byte1", cap_b[1], 8'hFF);
                check("sub_sc_in_byte0", cap_sc[0], 1'b1);
            end
            if (i == 4) check("shr_alu_a_msb_first", cap_a[0], 8'h01);
            if (i == 7) check("inv_alu_quiet", {cap_a[0], cap_b[1]}, 16'h0000);
            check($sformatf("idle_alu_quiet%0d", i), {ALU_A, ALU_B, ALU_OP, ALU_SC_IN}, 20'h0);
        end

        // Backpressure with a request waiting behind the response.
        RSP_READY = 1'b0;
        start_req(3'd0, 16'h1234, 16'h1111, 1'b0);
        collect(n);
        check("bp_latency", n, NB);
        REQ_VALID = 1'b1;
        REQ_OP    = 3'd3;
        REQ_A     = 16'h00FF;
        REQ_B     = 16'h0F0F;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_hold%0d", k), {RSP_VALID, REQ_READY, RSP_RESULT},
                  {1'b1, 1'b0, 16'h2345});
            @(negedge CLK);
        end
        RSP_READY = 1'b1;
        check("bp_still_valid", {RSP_VALID, REQ_READY}, 2'b10);
        @(negedge CLK);
        check("bp_idle_after_handshake", {RSP_VALID, REQ_READY}, 2'b01);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check("bp_pending_accepted", REQ_READY, 1'b0);
        collect(n);
        check("bp2_latency", n, NB);
        check("bp2_result", {RSP_RESULT, RSP_ZERO, RSP_COUT}, {16'h0FF0, 1'b0, 1'b0});
        @(negedge CLK);

        // Reset during the second RUN cycle.
        start_req(3'd1, 16'h5555, 16'h1111, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("midrun_reset_outputs",
              {REQ_READY, RSP_VALID, RSP_RESULT, RSP_COUT, RSP_ZERO, ALU_A, ALU_B, ALU_OP, ALU_SC_IN},
              {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0});
        @(negedge CLK);
        RESET = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check($sformatf("post_reset_idle%0d", k), {RSP_VALID, REQ_READY}, 2'b01);
        end
        run_vec("post_reset_add", 3'd0, 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            ref_model(rop, ra, rb, rc, er, ec);
            run_vec($sformatf("rand%0d_op%0d", r, rop), rop, ra, rb, rc, er, ec, er == '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
